// File: rtl/huff_pkg.sv
// Shared widths, timing constants and FSM state encoding for the Huffman stream feeder.
package huff_pkg;

  localparam int WORD_W      = 32;
  localparam int CHUNK_W     = 4;
  localparam int LEN_W       = 3;
  localparam int CNT_W       = 16;
  localparam int DRAIN_CYC   = 16;
  localparam int TIMEOUT_CYC = 255;

  localparam int WB_W    = $clog2(WORD_W + 1);
  localparam int QUIET_W = $clog2(DRAIN_CYC + 1);
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FEED  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/huff_chunk_slicer.sv
// Picks the next chunk length (bounded by chunk width, buffered bits and stream remainder)
// and right-aligns the top bits of the word buffer.
module huff_chunk_slicer
  import huff_pkg::*;
(
  input  logic [WORD_W-1:0]  wbuf,
  input  logic [WB_W-1:0]    wbits,
  input  logic [CNT_W-1:0]   rem,
  output logic [LEN_W-1:0]   len,
  output logic [CHUNK_W-1:0] bits
);

  logic [CNT_W-1:0]   lim_wb;
  logic [CNT_W-1:0]   lim;
  logic [CHUNK_W-1:0] top;

  always_comb begin
    lim_wb = (CNT_W'(wbits) < CNT_W'(CHUNK_W)) ? CNT_W'(wbits) : CNT_W'(CHUNK_W);
    lim    = (rem < lim_wb) ? rem : lim_wb;
    len    = LEN_W'(lim);
    top    = wbuf[WORD_W-1 -: CHUNK_W];
    // Shift the unused low bits out so the first stream bit lands at bits[len-1].
    bits   = top >> (LEN_W'(CHUNK_W) - len);
  end

endmodule

// File: rtl/huff_stream_feeder.sv
// Fetches packed bitstream words, paces 1..CHUNK_W-bit chunks into the Huffman decoder,
// counts decoded symbols, drains the decoder and reports done or a stall error.
module huff_stream_feeder
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   total_bits,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               dec_ready,
  output logic               sValid,
  output logic [CHUNK_W-1:0] in_bits,
  output logic [LEN_W-1:0]   in_len,
  input  logic               tvalid,
  output logic [CNT_W-1:0]   sym_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [WORD_W-1:0]   wbuf_q, wbuf_d;
  logic [WB_W-1:0]     wbits_q, wbits_d;
  logic [QUIET_W-1:0]  quiet_q, quiet_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                word_ready_q, word_ready_d;
  logic                svalid_q, svalid_d;
  logic [CHUNK_W-1:0]  in_bits_q, in_bits_d;
  logic [LEN_W-1:0]    in_len_q, in_len_d;
  logic [CNT_W-1:0]    sym_count_q, sym_count_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0]    sl_len;
  logic [CHUNK_W-1:0]  sl_bits;

  huff_chunk_slicer u_slicer (
    .wbuf  (wbuf_q),
    .wbits (wbits_q),
    .rem   (rem_q),
    .len   (sl_len),
    .bits  (sl_bits)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wbuf_d      = wbuf_q;
    wbits_d     = wbits_q;
    quiet_d     = quiet_q;
    stall_d     = {STALL_W{1'b0}};
    svalid_d    = 1'b0;
    in_bits_d   = {CHUNK_W{1'b0}};
    in_len_d    = {LEN_W{1'b0}};
    done_d      = 1'b0;
    err_d       = err_q;
    if (busy_q && tvalid && (sym_count_q != {CNT_W{1'b1}})) begin
      sym_count_d = sym_count_q + CNT_W'(1);
    end else begin
      sym_count_d = sym_count_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d       = total_bits;
          sym_count_d = {CNT_W{1'b0}};
          err_d       = 1'b0;
          state_d     = (total_bits == {CNT_W{1'b0}}) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (word_valid && word_ready_q) begin
          wbuf_d  = word_data;
          wbits_d = WB_W'(WORD_W);
          state_d = S_FEED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FEED: begin
        if (dec_ready) begin
          svalid_d  = 1'b1;
          in_bits_d = sl_bits;
          in_len_d  = sl_len;
          wbuf_d    = wbuf_q << sl_len;
          wbits_d   = wbits_q - WB_W'(sl_len);
          rem_d     = rem_q - CNT_W'(sl_len);
          state_d   = S_GAP;
        end else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      // One dead cycle lets the decoder refresh dec_ready before the next chunk.
      S_GAP: begin
        quiet_d = {QUIET_W{1'b0}};
        if (rem_q == {CNT_W{1'b0}}) begin
          state_d = S_DRAIN;
        end else if (wbits_q == {WB_W{1'b0}}) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_FEED;
        end
      end
      S_DRAIN: begin
        if (tvalid) begin
          quiet_d = {QUIET_W{1'b0}};
        end else if (quiet_q == QUIET_W'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
        end else begin
          quiet_d = quiet_q + QUIET_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    word_ready_d = (state_d == S_FETCH);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rem_q        <= {CNT_W{1'b0}};
      wbuf_q       <= {WORD_W{1'b0}};
      wbits_q      <= {WB_W{1'b0}};
      quiet_q      <= {QUIET_W{1'b0}};
      stall_q      <= {STALL_W{1'b0}};
      word_ready_q <= 1'b0;
      svalid_q     <= 1'b0;
      in_bits_q    <= {CHUNK_W{1'b0}};
      in_len_q     <= {LEN_W{1'b0}};
      sym_count_q  <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      wbuf_q       <= wbuf_d;
      wbits_q      <= wbits_d;
      quiet_q      <= quiet_d;
      stall_q      <= stall_d;
      word_ready_q <= word_ready_d;
      svalid_q     <= svalid_d;
      in_bits_q    <= in_bits_d;
      in_len_q     <= in_len_d;
      sym_count_q  <= sym_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign word_ready = word_ready_q;
  assign sValid     = svalid_q;
  assign in_bits    = in_bits_q;
  assign in_len     = in_len_q;
  assign sym_count  = sym_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_huff_stream_feeder.sv
// Directed bench for huff_stream_feeder: word source, dec_ready pattern, chunk scoreboard.
module tb_huff_stream_feeder;
  import huff_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, tvalid = 1'b0;
  logic [15:0] total_bits = 16'h0;
  logic [31:0] word_data = 32'h0;
  logic        word_valid = 1'b0;
  logic        word_ready, dec_ready, sValid, busy, done, err;
  logic [3:0]  in_bits;
  logic [2:0]  in_len;
  logic [15:0] sym_count;

  int          checks = 0;
  int          errors = 0;
  int          xfers = 0;
  int          chunks = 0;
  int          cyc = 0;
  int          n = 0;
  logic [31:0] words[$];
  logic [6:0]  exp_q[$];
  logic        xfer_n = 1'b0;
  logic        dr_mode = 1'b0, dr_level = 1'b0, dr_toggle = 1'b0;
  logic        dr_prev = 1'b0, sv_prev = 1'b0;

  assign dec_ready = dr_mode ? dr_toggle : dr_level;

  always #5 clk = ~clk;

  huff_stream_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total_bits (total_bits),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .dec_ready  (dec_ready),
    .sValid     (sValid),
    .in_bits    (in_bits),
    .in_len     (in_len),
    .tvalid     (tvalid),
    .sym_count  (sym_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int nbits);
    total_bits = 16'(nbits);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  // Reference slicing, one bit at a time, MSB of each word first.
  task automatic model(input int nbits, input logic [31:0] w0, input logic [31:0] w1);
    int rem;
    int p;
    int len;
    logic [31:0] wv;
    logic [3:0]  b;
    rem = nbits;
    for (int wi = 0; wi < 2 && rem > 0; wi++) begin
      wv = (wi == 0) ? w0 : w1;
      p = 0;
      while (p < 32 && rem > 0) begin
        len = 4;
        if (32 - p < len) len = 32 - p;
        if (rem < len) len = rem;
        b = 4'h0;
        for (int k = 0; k < len; k++) b = {b[2:0], wv[31 - p - k]};
        exp_q.push_back({3'(len), b});
        p += len;
        rem -= len;
      end
    end
  endtask

  always @(negedge clk) xfer_n = word_valid && word_ready;

  always @(posedge clk) begin
    #1;
    if (xfer_n) begin
      void'(words.pop_front());
      xfers++;
    end
    word_valid = (words.size() != 0);
    word_data  = (words.size() != 0) ? words[0] : 32'h0;
    cyc++;
    dr_toggle  = ((cyc % 4) == 0);
  end

  always @(negedge clk) begin
    if (sValid === 1'b1) begin
      chunks++;
      check("no_back_to_back", 32'(sv_prev), 32'h0);
      check("ready_before_chunk", 32'(dr_prev), 32'h1);
      check("chunk_expected", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) check("chunk_len_bits", 32'({in_len, in_bits}), 32'(exp_q.pop_front()));
    end
    dr_prev = dec_ready;
    sv_prev = sValid;
  end

  initial begin
    tick();
    tick();
    check("rst_word_ready", 32'(word_ready), 32'h0);
    check("rst_svalid", 32'(sValid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_in_len", 32'(in_len), 32'h0);
    check("rst_sym_count", 32'(sym_count), 32'h0);
    reset = 1'b0;
    tick();

    // 7-bit stream out of one word
    dr_level = 1'b1;
    words.push_back(32'hF400_0000);
    exp_q.push_back({3'd4, 4'b1111});
    exp_q.push_back({3'd3, 4'b0010});
    go(7);
    check("t1_busy", 32'(busy), 32'h1);
    wait_done(100, n);
    check("t1_done", 32'(done), 32'h1);
    check("t1_err", 32'(err), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_sym", 32'(sym_count), 32'h0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'h0);
    check("t1_xfers", 32'(xfers), 32'h1);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);

    // 34 bits across two words
    xfers = 0;
    chunks = 0;
    words.push_back(32'h1234_5678);
    words.push_back(32'hC0FF_EE00);
    model(34, 32'h1234_5678, 32'hC0FF_EE00);
    go(34);
    wait_done(200, n);
    check("t2_done", 32'(done), 32'h1);
    check("t2_xfers", 32'(xfers), 32'h2);
    check("t2_chunks", 32'(chunks), 32'h9);
    check("t2_sb_empty", 32'(exp_q.size()), 32'h0);

    // dec_ready high one cycle in four
    xfers = 0;
    chunks = 0;
    dr_mode = 1'b1;
    words.push_back(32'hA5A5_F00F);
    words.push_back(32'h3C3C_9696);
    model(40, 32'hA5A5_F00F, 32'h3C3C_9696);
    go(40);
    wait_done(400, n);
    check("t3_done", 32'(done), 32'h1);
    check("t3_chunks", 32'(chunks), 32'd10);
    check("t3_sb_empty", 32'(exp_q.size()), 32'h0);
    dr_mode = 1'b0;

    // symbol counting through DRAIN and the quiet window
    dr_level = 1'b1;
    words.push_back(32'h89AB_CDEF);
    model(20, 32'h89AB_CDEF, 32'h0);
    go(20);
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1;
      tick();
      tvalid = 1'b0;
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    check("t4_not_done_yet", 32'(done), 32'h0);
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    wait_done(100, n);
    check("t4_done", 32'(done), 32'h1);
    check("t4_quiet_cycles", 32'(n), 32'(DRAIN_CYC + 1));
    check("t4_sym", 32'(sym_count), 32'd6);
    check("t4_sb_empty", 32'(exp_q.size()), 32'h0);
    tick();
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    check("t4_idle_tvalid_ignored", 32'(sym_count), 32'd6);

    // stall after the first chunk
    chunks = 0;
    words.push_back(32'hDEAD_BEEF);
    exp_q.push_back({3'd4, 4'hD});
    go(32);
    n = 0;
    while (sValid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    dr_level = 1'b0;
    check("t5_first_chunk", 32'(sValid), 32'h1);
    wait_done(400, n);
    check("t5_done", 32'(done), 32'h1);
    check("t5_timeout_cycles", 32'(n), 32'(TIMEOUT_CYC + 2));
    check("t5_err", 32'(err), 32'h1);
    check("t5_chunks", 32'(chunks), 32'h1);
    tick();
    go(0);
    check("t5_err_cleared", 32'(err), 32'h0);
    check("t5_zero_busy", 32'(busy), 32'h1);
    tick();
    check("t5_zero_done", 32'(done), 32'h1);

    // reset while parked in FEED, then a zero-length stream
    words.push_back(32'h0F0F_0F0F);
    go(32);
    tvalid = 1'b1;
    tick();
    tick();
    tvalid = 1'b0;
    tick();
    check("t6_sym_before_reset", 32'(sym_count), 32'h2);
    check("t6_busy_before_reset", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_sym", 32'(sym_count), 32'h0);
    check("t6_rst_word_ready", 32'(word_ready), 32'h0);
    check("t6_rst_out", 32'({sValid, done, err, in_len, in_bits}), 32'h0);
    reset = 1'b0;
    tick();
    go(0);
    check("t6_zero_busy", 32'(busy), 32'h1);
    check("t6_zero_no_done_yet", 32'(done), 32'h0);
    tick();
    check("t6_zero_done", 32'(done), 32'h1);
    check("t6_zero_busy_low", 32'(busy), 32'h0);
    check("t6_no_chunks", 32'(chunks), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
